// File: rtl/uart_tx_param.sv
// Word FIFO feeding the UART frame engine; power-of-2 depth, pointers wrap naturally.
// Latency: a pushed word is visible at the head (level != 0) one cycle after the push.
// Backpressure: wr_rdy drops while full; a held write is ignored until space frees up.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_go;

    assign wr_rdy = (level < (AW+1)'(DEPTH));
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_go  = rd_en & (level != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_go) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_go})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Parameterised UART transmitter: FIFO-buffered words sent as start/data/parity/stop frames.
// Latency: push in cycle N into an idle, empty block puts the start bit on tx from N+2.
// Backpressure: tx_ready low while the FIFO holds FIFO_DEPTH words; frames run back-to-back.
module uart_tx_param #(
    parameter int FCLK       = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = FCLK / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_tx_param: FCLK must be at least BAUD");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   pop;
    logic                   load;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   head_dat;

    uart_tx_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (tx_valid),
        .wr_rdy (tx_ready),
        .wr_dat (tx_data),
        .rd_en  (pop),
        .rd_dat (head_dat),
        .level  (fifo_level)
    );

    assign bit_end = (cnt_q == CW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fifo_level != '0) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        // Chain straight into the next frame so there is no idle gap.
                        if (fifo_level != '0) load = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = head_dat;
            par_d   = (^head_dat) ^ (PARITY == 2);
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || (fifo_level != '0);
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations checked against a frame-level line model every cycle,
// plus directed frames with hand-computed waveforms.
module tb_uart_tx_param;
    localparam int NI = 5;
    localparam int DIVS [NI] = '{10, 10, 10, 10, 2};
    localparam int DB   [NI] = '{8, 7, 7, 8, 9};
    localparam int PAR  [NI] = '{0, 1, 2, 0, 2};
    localparam int SB   [NI] = '{1, 1, 1, 2, 2};
    localparam int DEP  [NI] = '{4, 16, 16, 16, 4};

    logic          clk;
    logic          rst_n;
    logic [8:0]    dat_a [NI];
    logic [NI-1:0] vld_a;
    logic [NI-1:0] rdy_w;
    logic [NI-1:0] tx_w;
    logic [NI-1:0] busy_w;
    logic [4:0]    lvl_w [NI];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wire [$clog2(DEP[g]):0] lv;
        uart_tx_param #(
            .FCLK       (DIVS[g] * 100000),
            .BAUD       (100000),
            .DATA_BITS  (DB[g]),
            .PARITY     (PAR[g]),
            .STOP_BITS  (SB[g]),
            .FIFO_DEPTH (DEP[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .tx_data    (dat_a[g][DB[g]-1:0]),
            .tx_valid   (vld_a[g]),
            .tx_ready   (rdy_w[g]),
            .tx         (tx_w[g]),
            .busy       (busy_w[g]),
            .fifo_level (lv)
        );
        assign lvl_w[g] = 5'(lv);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line bits of one frame, index 0 = start bit; unused upper bits are idle-high.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db, input int par);
        logic [15:0] f;
        logic p;
        f = '1;
        p = 1'b0;
        f[0] = 1'b0;
        for (int k = 0; k < db; k++) begin
            f[1+k] = d[k];
            p = p ^ d[k];
        end
        if (par != 0) f[1+db] = (par == 2) ? ~p : p;
        return f;
    endfunction

    // Line model: queue of words plus position inside the current frame (-1 = idle).
    logic [8:0]  mq   [NI][16];
    int          mh   [NI];
    int          mt   [NI];
    int          fpos [NI];
    int          flen [NI];
    logic [15:0] fb   [NI];

    initial begin
        int  lvl;
        logic etx;
        logic pop;
        logic psh;
        for (int i = 0; i < NI; i++) begin
            mh[i] = 0; mt[i] = 0; fpos[i] = -1; flen[i] = 1; fb[i] = '1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    mh[i] = 0; mt[i] = 0; fpos[i] = -1;
                end
                lvl = mt[i] - mh[i];
                etx = (fpos[i] >= 0) ? fb[i][fpos[i] / DIVS[i]] : 1'b1;
                chk($sformatf("cyc_tx%0d", i), 32'(tx_w[i]), 32'(etx));
                chk($sformatf("cyc_lvl%0d", i), 32'(lvl_w[i]), lvl);
                chk($sformatf("cyc_rdy%0d", i), 32'(rdy_w[i]), 32'(lvl < DEP[i]));
                chk($sformatf("cyc_busy%0d", i), 32'(busy_w[i]), 32'(fpos[i] >= 0 || lvl != 0));
                if (rst_n) begin
                    pop = (lvl != 0) && (fpos[i] < 0 || fpos[i] == flen[i] - 1);
                    psh = vld_a[i] && (lvl < DEP[i]);
                    if (pop) begin
                        fb[i]   = frame_bits(mq[i][mh[i] % 16], DB[i], PAR[i]);
                        flen[i] = (1 + DB[i] + (PAR[i] != 0 ? 1 : 0) + SB[i]) * DIVS[i];
                        mh[i]++;
                        fpos[i] = 0;
                    end else if (fpos[i] >= 0) begin
                        fpos[i] = (fpos[i] == flen[i] - 1) ? -1 : fpos[i] + 1;
                    end
                    if (psh) begin
                        mq[i][mt[i] % 16] = dat_a[i];
                        mt[i]++;
                    end
                end
            end
        end
    end

    // 100-cycle, 10-bit frame on instance i starting now; pat[0] is the start bit.
    task automatic frame_chk(input int i, input logic [9:0] pat, input string nm);
        for (int c = 0; c < 100; c++) begin
            chk(nm, 32'(tx_w[i]), 32'(pat[c/10]));
            chk({nm, "_busy"}, 32'(busy_w[i]), 1);
            tick();
        end
    endtask

    initial begin
        int words;
        int cyc;
        logic acc;
        logic [8:0] w;
        vld_a = '0;
        for (int i = 0; i < NI; i++) dat_a[i] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_tx", 32'(tx_w[i]), 1);
            chk("rst_rdy", 32'(rdy_w[i]), 1);
            chk("rst_busy", 32'(busy_w[i]), 0);
            chk("rst_lvl", 32'(lvl_w[i]), 0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // 8N1, 0xA5
        dat_a[0] = 9'h0A5; vld_a[0] = 1'b1; tick(); vld_a[0] = 1'b0;
        chk("a5_lvl_n1", 32'(lvl_w[0]), 1);
        chk("a5_tx_n1", 32'(tx_w[0]), 1);
        tick();
        frame_chk(0, 10'b1101001010, "a5_bit");
        chk("a5_busy_end", 32'(busy_w[0]), 0);
        chk("a5_tx_end", 32'(tx_w[0]), 1);

        // 7E1 / 7O1, 0x55: four ones, so even parity 0 and odd parity 1
        dat_a[1] = 9'h055; dat_a[2] = 9'h055; vld_a[1] = 1'b1; vld_a[2] = 1'b1;
        tick(); vld_a[1] = 1'b0; vld_a[2] = 1'b0;
        tick();
        for (int c = 0; c < 100; c++) begin
            if (c == 0) chk("par_start", 32'(tx_w[1]), 0);
            if (c / 10 == 8) begin
                chk("par_even", 32'(tx_w[1]), 0);
                chk("par_odd", 32'(tx_w[2]), 1);
            end
            if (c == 99) chk("par_busy_last", 32'(busy_w[2]), 1);
            tick();
        end
        chk("par_len_even", 32'(busy_w[1]), 0);
        chk("par_len_odd", 32'(busy_w[2]), 0);

        // 8N2: 0x00 then 0xFF, exactly 20 high cycles between them
        dat_a[3] = 9'h000; vld_a[3] = 1'b1; tick();
        dat_a[3] = 9'h0FF; tick(); vld_a[3] = 1'b0;
        for (int c = 0; c <= 110; c++) begin
            chk("stop2_gap", 32'(tx_w[3]), 32'(c >= 90 && c < 110));
            tick();
        end
        repeat (109) tick();
        chk("stop2_done", 32'(busy_w[3]), 0);

        // FIFO full with depth 4, then back-to-back drain
        dat_a[0] = 9'h001; vld_a[0] = 1'b1; tick(); vld_a[0] = 1'b0; tick();
        for (int k = 0; k < 7; k++) begin
            dat_a[0] = 9'(16 + ((k < 4) ? k : 4));
            vld_a[0] = 1'b1;
            chk("full_lvl", 32'(lvl_w[0]), (k < 4) ? k : 4);
            chk("full_rdy", 32'(rdy_w[0]), 32'(k < 4));
            tick();
        end
        vld_a[0] = 1'b0;
        for (int c = 7; c <= 500; c++) begin
            if (c < 500) chk("b2b_busy", 32'(busy_w[0]), 1);
            if (c % 100 == 0 && c < 500) chk("b2b_start", 32'(tx_w[0]), 0);
            if (c % 100 == 99) chk("b2b_stop", 32'(tx_w[0]), 1);
            if (c == 500) chk("b2b_idle", 32'(busy_w[0]), 0);
            tick();
        end

        // Reset during data bit 3 with two words queued
        dat_a[0] = 9'h011; vld_a[0] = 1'b1; tick();
        dat_a[0] = 9'h022; tick();
        dat_a[0] = 9'h033; tick(); vld_a[0] = 1'b0;
        chk("q_lvl", 32'(lvl_w[0]), 2);
        repeat (42) tick();
        chk("mid_bit3", 32'(tx_w[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_w[0]), 1);
        chk("abort_lvl", 32'(lvl_w[0]), 0);
        chk("abort_busy", 32'(busy_w[0]), 0);
        chk("abort_rdy", 32'(rdy_w[0]), 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        dat_a[0] = 9'h03C; vld_a[0] = 1'b1; tick(); vld_a[0] = 1'b0;
        chk("3c_lvl_n1", 32'(lvl_w[0]), 1);
        chk("3c_tx_n1", 32'(tx_w[0]), 1);
        tick();
        frame_chk(0, 10'b1001111000, "3c_bit");
        chk("3c_busy_end", 32'(busy_w[0]), 0);

        // Random push/stall traffic on 9O2, DIV=2
        words = 0;
        cyc   = 0;
        w     = 9'($urandom);
        while (words < 1000 && cyc < 60000) begin
            dat_a[4] = w;
            vld_a[4] = ($urandom_range(0, 3) != 0);
            acc = vld_a[4] && rdy_w[4];
            tick();
            cyc++;
            if (acc) begin
                words++;
                w = 9'($urandom);
            end
        end
        vld_a[4] = 1'b0;
        chk("rand_words", words, 1000);
        repeat (300) tick();
        chk("rand_drain", 32'(busy_w[4]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
